// File: rtl/calendar_pkg.sv
// Shared types, constants and leap-year helper for the BCD calendar counter.
package calendar_pkg;

  typedef logic [3:0] bcd_t;

  // Year is sized for the widest build; 2-digit builds keep the upper digits at zero.
  typedef struct packed {
    logic [15:0] year;
    logic [7:0]  month;
    logic [7:0]  day;
  } date_t;

  localparam logic [7:0] LEN_31    = 8'h31;
  localparam logic [7:0] LEN_30    = 8'h30;
  localparam logic [7:0] LEN_29    = 8'h29;
  localparam logic [7:0] LEN_28    = 8'h28;
  localparam logic [7:0] DAY_MIN   = 8'h01;
  localparam logic [7:0] MONTH_MIN = 8'h01;
  localparam logic [7:0] MONTH_MAX = 8'h12;
  localparam bcd_t       BCD_MAX   = 4'd9;
  localparam logic [2:0] DOW_RST   = 3'd6;
  localparam logic [2:0] DOW_MAX   = 3'd6;

  function automatic logic bcd2_div4(input logic [7:0] v);
    logic [6:0] b;
    b = 7'(v[7:4]) * 7'd10 + 7'(v[3:0]);
    return (b[1:0] == 2'b00);
  endfunction

  // yy = low two year digits, cc = century digits (BCD); equivalent to the Gregorian rule.
  function automatic logic is_leap(input logic [7:0] yy, input logic [7:0] cc);
    if (yy == 8'h00) return bcd2_div4(cc);
    return bcd2_div4(yy);
  endfunction

  function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
    if (v[3:0] == BCD_MAX) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/calendar_date_ctr_if.sv
// Tick/adjust/load/data bundle of the calendar counter; CAL_DOW_EN adds the day-of-week signals.
interface calendar_date_ctr_if #(
  parameter int unsigned YEAR_DIGITS = 2
) ();
  localparam int unsigned DW = 16 + 4 * YEAR_DIGITS;

  logic          day_tick;
  logic [2:0]    adj_inc;
  logic          set_valid;
  logic          set_ready;
  logic [DW-1:0] set_date;
  logic          set_err;
  logic          year_wrap;
  logic [DW-1:0] Data;
`ifdef CAL_DOW_EN
  logic [2:0]    dow;
  logic [2:0]    set_dow;

  modport master (output day_tick, adj_inc, set_valid, set_date, set_dow,
                  input  set_ready, set_err, year_wrap, Data, dow);
  modport slave  (input  day_tick, adj_inc, set_valid, set_date, set_dow,
                  output set_ready, set_err, year_wrap, Data, dow);
`else
  modport master (output day_tick, adj_inc, set_valid, set_date,
                  input  set_ready, set_err, year_wrap, Data);
  modport slave  (input  day_tick, adj_inc, set_valid, set_date,
                  output set_ready, set_err, year_wrap, Data);
`endif
endinterface

// File: rtl/cal_month_len.sv
// Combinational month length (BCD day count) for a BCD month/year pair.
module cal_month_len
  import calendar_pkg::*;
#(
  parameter int unsigned YEAR_DIGITS = 2,
  parameter int unsigned CENTURY     = 20
) (
  input  logic [7:0]               month,
  input  logic [4*YEAR_DIGITS-1:0] year,
  output logic [7:0]               len_c
);
  localparam logic [7:0] CENT_BCD = 8'(((CENTURY / 10) % 10) * 16 + (CENTURY % 10));

  logic [7:0] cc;
  logic       leap_c;

  // 4-digit builds take the century from the year itself
  assign cc     = (YEAR_DIGITS == 4) ? year[4*YEAR_DIGITS-1 -: 8] : CENT_BCD;
  assign leap_c = is_leap(year[7:0], cc);

  always_comb begin
    len_c = LEN_31;
    case (month)
      8'h02:                      len_c = leap_c ? LEN_29 : LEN_28;
      8'h04, 8'h06, 8'h09, 8'h11: len_c = LEN_30;
      default:                    len_c = LEN_31;
    endcase
  end
endmodule

// File: rtl/calendar_date_ctr.sv
// BCD day/month/year counter with tick carry, manual adjust and validated load.
// Optional day-of-week tracking is enabled with `define CAL_DOW_EN.
module calendar_date_ctr
  import calendar_pkg::*;
#(
  parameter int unsigned YEAR_DIGITS = 2,
  parameter int unsigned CENTURY     = 20
) (
  input  logic               Clk,
  input  logic               Reset,
  calendar_date_ctr_if.slave bus
);
  localparam int unsigned YW   = 4 * YEAR_DIGITS;
  localparam int unsigned DW   = 16 + YW;
  localparam int unsigned NIBS = 8;

  typedef enum logic {IDLE, CHECK} state_t;

  state_t        state;
  logic [7:0]    day, month;
  logic [YW-1:0] year;
  date_t         cap;
  logic [DW-1:0] data_q;
  logic          ready_q, err_q, wrap_q;

  logic [YW-1:0] year_inc_c, sel_year_c, cap_year_c;
  logic          year_max_c, carry_c, adj_one_c, chk_ok_c;
  logic [7:0]    month_inc_c, sel_month_c, live_len_c, chk_len_c;
  logic [31:0]   cap_flat_c;
`ifdef CAL_DOW_EN
  logic [2:0]    dow_q, cap_dow;
  assign bus.dow = dow_q;
`endif

  assign bus.Data      = data_q;
  assign bus.set_ready = ready_q;
  assign bus.set_err   = err_q;
  assign bus.year_wrap = wrap_q;

  // Decimal year increment; carry out of the top digit marks the all-9s year
  always_comb begin
    year_inc_c = year;
    carry_c    = 1'b1;
    for (int i = 0; i < int'(YEAR_DIGITS); i++) begin
      if (carry_c) begin
        if (year[4*i +: 4] == BCD_MAX) year_inc_c[4*i +: 4] = 4'd0;
        else begin
          year_inc_c[4*i +: 4] = year[4*i +: 4] + 4'd1;
          carry_c = 1'b0;
        end
      end
    end
    year_max_c = carry_c;
  end

  assign month_inc_c = (month == MONTH_MAX) ? MONTH_MIN : bcd2_inc(month);
  assign adj_one_c   = $onehot(bus.adj_inc);

  // Live length follows the field an adjust is about to write, so the day clamp sees the new month/year
  always_comb begin
    sel_month_c = month;
    sel_year_c  = year;
    if (!bus.day_tick && adj_one_c) begin
      if (bus.adj_inc[1]) sel_month_c = month_inc_c;
      if (bus.adj_inc[2]) sel_year_c  = year_inc_c;
    end
  end

  cal_month_len #(.YEAR_DIGITS(YEAR_DIGITS), .CENTURY(CENTURY)) u_live_len (
    .month(sel_month_c), .year(sel_year_c), .len_c(live_len_c));

  assign cap_year_c = cap.year[YW-1:0];
  assign cap_flat_c = {cap.year, cap.month, cap.day};

  cal_month_len #(.YEAR_DIGITS(YEAR_DIGITS), .CENTURY(CENTURY)) u_chk_len (
    .month(cap.month), .year(cap_year_c), .len_c(chk_len_c));

  always_comb begin
    chk_ok_c = (cap.month >= MONTH_MIN) && (cap.month <= MONTH_MAX) &&
               (cap.day >= DAY_MIN) && (cap.day <= chk_len_c);
    for (int i = 0; i < int'(NIBS); i++)
      if (cap_flat_c[4*i +: 4] > BCD_MAX) chk_ok_c = 1'b0;
`ifdef CAL_DOW_EN
    if (cap_dow > DOW_MAX) chk_ok_c = 1'b0;
`endif
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      day     <= DAY_MIN;
      month   <= MONTH_MIN;
      year    <= '0;
      cap     <= '0;
      data_q  <= {{YW{1'b0}}, MONTH_MIN, DAY_MIN};
      ready_q <= 1'b1;
      err_q   <= 1'b0;
      wrap_q  <= 1'b0;
`ifdef CAL_DOW_EN
      dow_q   <= DOW_RST;
      cap_dow <= '0;
`endif
    end else begin
      err_q  <= 1'b0;
      wrap_q <= 1'b0;
      data_q <= {year, month, day};

      case (state)
        IDLE: if (bus.set_valid) begin
          cap.year  <= 16'(bus.set_date[DW-1 -: YW]);
          cap.month <= bus.set_date[15:8];
          cap.day   <= bus.set_date[7:0];
`ifdef CAL_DOW_EN
          cap_dow   <= bus.set_dow;
`endif
          ready_q   <= 1'b0;
          state     <= CHECK;
        end
        CHECK: begin
          ready_q <= 1'b1;
          err_q   <= !chk_ok_c;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Commit beats tick beats adjust; losers are dropped
      if (state == CHECK && chk_ok_c) begin
        day   <= cap.day;
        month <= cap.month;
        year  <= cap_year_c;
`ifdef CAL_DOW_EN
        dow_q <= cap_dow;
`endif
      end else if (bus.day_tick) begin
        if (day >= live_len_c) begin
          day <= DAY_MIN;
          if (month == MONTH_MAX) begin
            month  <= MONTH_MIN;
            year   <= year_inc_c;
            wrap_q <= year_max_c;
          end else begin
            month <= month_inc_c;
          end
        end else begin
          day <= bcd2_inc(day);
        end
`ifdef CAL_DOW_EN
        dow_q <= (dow_q == DOW_MAX) ? 3'd0 : dow_q + 3'd1;
`endif
      end else if (adj_one_c) begin
        if (bus.adj_inc[0]) begin
          day <= (day >= live_len_c) ? DAY_MIN : bcd2_inc(day);
        end else begin
          if (bus.adj_inc[1]) month <= month_inc_c;
          else                year  <= year_inc_c;
          if (day > live_len_c) day <= live_len_c;
        end
      end
    end
  end
endmodule

// File: tb/tb_calendar_date_ctr.sv
// Bench: 4-digit and 2-digit counters driven in lockstep, checked against an integer calendar model.
module tb_calendar_date_ctr;
  localparam int CENTURY = 20;
`ifdef CAL_DOW_EN
  localparam bit DOW_EN = 1'b1;
`else
  localparam bit DOW_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        tick, valid;
  logic [2:0]  adj, sdow;
  logic [31:0] date;
  bit          armed;

  calendar_date_ctr_if #(.YEAR_DIGITS(4)) bus4 ();
  calendar_date_ctr_if #(.YEAR_DIGITS(2)) bus2 ();

  assign bus4.day_tick  = tick;
  assign bus4.adj_inc   = adj;
  assign bus4.set_valid = valid;
  assign bus4.set_date  = date;
  assign bus2.day_tick  = tick;
  assign bus2.adj_inc   = adj;
  assign bus2.set_valid = valid;
  assign bus2.set_date  = date[23:0];
`ifdef CAL_DOW_EN
  assign bus4.set_dow = sdow;
  assign bus2.set_dow = sdow;
`endif

  calendar_date_ctr #(.YEAR_DIGITS(4), .CENTURY(CENTURY)) dut4 (.Clk(clk), .Reset(rst), .bus(bus4));
  calendar_date_ctr #(.YEAR_DIGITS(2), .CENTURY(CENTURY)) dut2 (.Clk(clk), .Reset(rst), .bus(bus2));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (k=0: 4-digit, k=1: 2-digit) ----------------
  int          my[2], mm[2], md[2], mdow[2];
  bit          pend, was, ok, e_ready;
  logic [31:0] cap_raw;
  logic [2:0]  cap_dow;
  logic [31:0] e_data[2];
  bit          e_err[2], e_wrap[2];
  int          ly, lm, ld;

  function automatic int ndig(input int k);
    return (k == 0) ? 4 : 2;
  endfunction

  function automatic bit leap(input int y, input int k);
    if (k == 0) return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
    if (y == 0) return (CENTURY % 4 == 0);
    return (y % 4 == 0);
  endfunction

  function automatic int dim(input int m, input int y, input int k);
    if (m == 2) return leap(y, k) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  function automatic logic [31:0] to_bcd(input int v, input int n);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < n; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] pack(input int k);
    return (to_bcd(my[k], ndig(k)) << 16) | (to_bcd(mm[k], 2) << 8) | to_bcd(md[k], 2);
  endfunction

  function automatic bit decode(input logic [31:0] raw, input int k,
                                output int y, output int m, output int d);
    bit g;
    int n;
    n = ndig(k);
    g = 1'b1;
    y = 0;
    for (int i = 0; i < 4 + n; i++) if (raw[4*i +: 4] > 4'd9) g = 1'b0;
    for (int j = n - 1; j >= 0; j--) y = y * 10 + int'(raw[16 + 4*j +: 4]);
    m = int'(raw[15:12]) * 10 + int'(raw[11:8]);
    d = int'(raw[7:4]) * 10 + int'(raw[3:0]);
    if (m < 1 || m > 12) g = 1'b0;
    else if (d < 1 || d > dim(m, y, k)) g = 1'b0;
    return g;
  endfunction

  task automatic advance(input int k);
    int ymod;
    ymod = (k == 0) ? 10000 : 100;
    mdow[k] = (mdow[k] + 1) % 7;
    if (md[k] < dim(mm[k], my[k], k)) md[k]++;
    else begin
      md[k] = 1;
      if (mm[k] < 12) mm[k]++;
      else begin
        mm[k] = 1;
        e_wrap[k] = (my[k] == ymod - 1);
        my[k] = (my[k] + 1) % ymod;
      end
    end
  endtask

  task automatic adjust(input int k, input logic [2:0] a);
    if (a[0]) md[k] = (md[k] == dim(mm[k], my[k], k)) ? 1 : md[k] + 1;
    else begin
      if (a[1]) mm[k] = (mm[k] == 12) ? 1 : mm[k] + 1;
      else      my[k] = (my[k] + 1) % ((k == 0) ? 10000 : 100);
      if (md[k] > dim(mm[k], my[k], k)) md[k] = dim(mm[k], my[k], k);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend = 1'b0;
      e_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
        my[k] = 0; mm[k] = 1; md[k] = 1; mdow[k] = 6;
        e_data[k] = pack(k);
        e_err[k] = 1'b0;
        e_wrap[k] = 1'b0;
      end
    end else begin
      was = pend;
      if (was) begin
        pend = 1'b0;
        e_ready = 1'b1;
      end else if (valid) begin
        pend = 1'b1;
        e_ready = 1'b0;
        cap_raw = date;
        cap_dow = sdow;
      end
      for (int k = 0; k < 2; k++) begin
        e_data[k] = pack(k);
        e_err[k] = 1'b0;
        e_wrap[k] = 1'b0;
        ok = 1'b0;
        if (was) ok = decode(cap_raw, k, ly, lm, ld) && (!DOW_EN || cap_dow <= 3'd6);
        if (was && !ok) e_err[k] = 1'b1;
        if (ok) begin
          my[k] = ly; mm[k] = lm; md[k] = ld; mdow[k] = int'(cap_dow);
        end else if (tick) advance(k);
        else if ($countones(adj) == 1) adjust(k, adj);
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (armed && !rst) begin
      check("data4",  bus4.Data, e_data[0]);
      check("data2",  32'(bus2.Data), e_data[1]);
      check("ready4", 32'(bus4.set_ready), 32'(e_ready));
      check("ready2", 32'(bus2.set_ready), 32'(e_ready));
      check("err4",   32'(bus4.set_err), 32'(e_err[0]));
      check("err2",   32'(bus2.set_err), 32'(e_err[1]));
      check("wrap4",  32'(bus4.year_wrap), 32'(e_wrap[0]));
      check("wrap2",  32'(bus2.year_wrap), 32'(e_wrap[1]));
`ifdef CAL_DOW_EN
      check("dow4", 32'(bus4.dow), 32'(mdow[0]));
      check("dow2", 32'(bus2.dow), 32'(mdow[1]));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit t, input logic [2:0] a, input bit v, input logic [31:0] dt);
    tick = t; adj = a; valid = v; date = dt;
    @(posedge clk); #1;
    tick = 1'b0; adj = '0; valid = 1'b0;
  endtask

  task automatic load(input logic [31:0] dt);
    cyc(1'b0, 3'b000, 1'b1, dt);
    cyc(1'b0, 3'b000, 1'b0, dt);
  endtask

  task automatic idle();
    cyc(1'b0, 3'b000, 1'b0, date);
  endtask

  task automatic tick1();
    cyc(1'b1, 3'b000, 1'b0, date);
  endtask

  initial begin
    int r, y;
    rst = 1'b1; tick = 1'b0; adj = '0; valid = 1'b0; date = '0; sdow = '0; armed = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    armed = 1'b1;
    check("rst_data4", bus4.Data, 32'h0000_0101);
    check("rst_data2", 32'(bus2.Data), 32'h0000_0101);
    check("rst_ready", 32'(bus4.set_ready), 32'd1);
    check("rst_err",   32'(bus4.set_err), 32'd0);

    // leap boundaries
    load(32'h2024_0228); tick1(); idle();
    check("lit_20240229", bus4.Data, 32'h2024_0229);
    tick1(); idle();
    check("lit_20240301", bus4.Data, 32'h2024_0301);
    load(32'h2100_0228); tick1(); idle();
    check("lit_21000301", bus4.Data, 32'h2100_0301);
    check("lit_000229_2d", 32'(bus2.Data), 32'h0000_0229);
    load(32'h2000_0228); tick1(); idle();
    check("lit_20000229", bus4.Data, 32'h2000_0229);

    // year wrap
    load(32'h1999_1231); tick1();
    check("lit_wrap2_hi", 32'(bus2.year_wrap), 32'd1);
    check("lit_wrap4_lo", 32'(bus4.year_wrap), 32'd0);
    idle();
    check("lit_wrap2_once", 32'(bus2.year_wrap), 32'd0);
    check("lit_000101_2d", 32'(bus2.Data), 32'h0000_0101);
    check("lit_20000101", bus4.Data, 32'h2000_0101);
    load(32'h1999_0101); cyc(1'b0, 3'b100, 1'b0, date);
    check("lit_adj_nowrap", 32'(bus2.year_wrap), 32'd0);
    idle();
    check("lit_adj_year2", 32'(bus2.Data), 32'h0000_0101);

    // rejected loads
    cyc(1'b0, 3'b000, 1'b1, 32'h2023_0229);
    check("lit_ready_low", 32'(bus4.set_ready), 32'd0);
    idle();
    check("lit_err_0229", 32'(bus4.set_err), 32'd1);
    check("lit_ready_back", 32'(bus4.set_ready), 32'd1);
    idle();
    check("lit_err_once", 32'(bus4.set_err), 32'd0);
    check("lit_unchanged", bus4.Data, 32'h2000_0101);
    load(32'h2023_1301);
    check("lit_err_month13", 32'(bus4.set_err), 32'd1);
    load(32'h2023_010A);
    check("lit_err_nibA", 32'(bus2.set_err), 32'd1);

    // adjust with clamp / in-place wrap
    load(32'h2023_0131); cyc(1'b0, 3'b010, 1'b0, date); idle();
    check("lit_clamp", bus4.Data, 32'h2023_0228);
    load(32'h2023_0430); cyc(1'b0, 3'b001, 1'b0, date); idle();
    check("lit_daywrap", bus4.Data, 32'h2023_0401);

    // priority
    load(32'h2023_0510); cyc(1'b1, 3'b001, 1'b0, date); idle();
    check("lit_tick_wins", bus4.Data, 32'h2023_0511);
    cyc(1'b0, 3'b000, 1'b1, 32'h2023_0701); tick1(); idle();
    check("lit_commit_wins", bus4.Data, 32'h2023_0701);

    // reset during CHECK
    cyc(1'b0, 3'b000, 1'b1, 32'h2024_1225);
    rst = 1'b1; #2 rst = 1'b0;
    @(posedge clk); #1;
    check("lit_rst_mid_data", bus4.Data, 32'h0000_0101);
    check("lit_rst_mid_err", 32'(bus4.set_err), 32'd0);
    check("lit_rst_mid_ready", 32'(bus4.set_ready), 32'd1);
`ifdef CAL_DOW_EN
    repeat (7) tick1();
    check("lit_dow_week", 32'(bus4.dow), 32'd6);
`endif

    // randomized phase
    repeat (4000) begin
      r = $urandom_range(0, 9);
      if (r == 0) date = $urandom();
      else if (r == 1) date = 32'h9999_1231;
      else begin
        y = $urandom_range(0, 9999);
        date = (to_bcd(y, 4) << 16) | (to_bcd($urandom_range(1, 13), 2) << 8) |
               to_bcd($urandom_range(0, 31), 2);
      end
      sdow = 3'($urandom_range(0, 7));
      cyc(($urandom_range(0, 9) < 4),
          ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000,
          ($urandom_range(0, 6) == 0), date);
    end

    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
